// File: rtl/fft_r2_core.sv
// In-place radix-2 DIT FFT engine over an external single-port memory and twiddle ROM.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (1/N overall); default wraps to DW bits.
module fft_r2_core #(
  parameter int LOG2N = 10,
  parameter int DW    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inv,
  output logic              ready,
  output logic              cs,
  output logic              we,
  output logic [LOG2N-1:0]  addr,
  output logic [2*DW-1:0]   w_data,
  input  logic [2*DW-1:0]   r_data,
  output logic [LOG2N-2:0]  tw_addr,
  input  logic [2*DW-1:0]   tw_data
);
  localparam int SW = $clog2(LOG2N);
  localparam int PW = 2*DW + 2;

  typedef enum logic [3:0] {
    IDLE, BR_RA, BR_RB, BR_CAP, BR_WA, BR_WB,
    BF_RA, BF_RB, BF_CAP, BF_WA, BF_WB, DONE
  } state_t;

  state_t           state, state_n;
  logic [LOG2N-1:0] idx, idx_n;
  logic [SW-1:0]    stg, stg_n;
  logic [LOG2N-2:0] bfly, bfly_n;
  logic             inv_q, inv_n;
  logic [2*DW-1:0]  op_a, op_a_n, op_b, op_b_n, w_data_n;
  logic             ready_n, cs_n, we_n;
  logic [LOG2N-1:0] addr_n;
  logic [LOG2N-2:0] tw_addr_n;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  // Butterfly j of stage s: low index inserts a zero at bit s of j, twiddle is offset << (LOG2N-1-s)
  logic [LOG2N-1:0] rev_cur, rev_n, jw_n, mask_n, lo_n, hi_n;
  logic [LOG2N-2:0] k_n;
  assign rev_cur = bit_rev(idx);
  assign rev_n   = bit_rev(idx_n);
  assign jw_n    = {1'b0, bfly_n};
  assign mask_n  = (LOG2N'(1) << stg_n) - LOG2N'(1);
  assign lo_n    = ((jw_n & ~mask_n) << 1) | (jw_n & mask_n);
  assign hi_n    = lo_n | (LOG2N'(1) << stg_n);
  assign k_n     = (LOG2N-1)'(jw_n & mask_n) << (SW'(LOG2N-1) - stg_n);

  logic signed [DW-1:0] ar, ai, br, bi, wr, wi;
  logic signed [DW:0]   wi_ext, wi_eff, t_re, t_im, sum_re, sum_im, dif_re, dif_im;
  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, t_re_full, t_im_full;
  logic [DW-1:0]        a_re, a_im, b_re, b_im;

  assign {ar, ai} = op_a;
  assign {br, bi} = r_data;
  assign {wr, wi} = tw_data;
  // Negation at DW+1 bits so a -1.0 imaginary twiddle conjugates without overflow
  assign wi_ext = {wi[DW-1], wi};
  assign wi_eff = inv_q ? -wi_ext : wi_ext;
  assign br_x   = PW'(br);
  assign bi_x   = PW'(bi);
  assign wr_x   = PW'(wr);
  assign wi_x   = PW'(wi_eff);
  assign t_re_full = br_x * wr_x - bi_x * wi_x;
  assign t_im_full = br_x * wi_x + bi_x * wr_x;
  assign t_re   = (DW+1)'(t_re_full >>> (DW-1));
  assign t_im   = (DW+1)'(t_im_full >>> (DW-1));
  assign sum_re = (DW+1)'(ar) + t_re;
  assign sum_im = (DW+1)'(ai) + t_im;
  assign dif_re = (DW+1)'(ar) - t_re;
  assign dif_im = (DW+1)'(ai) - t_im;

`ifdef FFT_STAGE_SCALE_EN
  assign a_re = DW'(sum_re >>> 1);
  assign a_im = DW'(sum_im >>> 1);
  assign b_re = DW'(dif_re >>> 1);
  assign b_im = DW'(dif_im >>> 1);
`else
  assign a_re = DW'(sum_re);
  assign a_im = DW'(sum_im);
  assign b_re = DW'(dif_re);
  assign b_im = DW'(dif_im);
`endif

  // op_b always holds the word for the second write, so WA -> WB is shared by both phases
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    stg_n    = stg;
    bfly_n   = bfly;
    inv_n    = inv_q;
    op_a_n   = op_a;
    op_b_n   = op_b;
    w_data_n = w_data;
    case (state)
      IDLE: if (start) begin
        state_n = BR_RA;
        idx_n   = '0;
        stg_n   = '0;
        bfly_n  = '0;
        inv_n   = inv;
      end
      BR_RA: begin
        if (idx < rev_cur) state_n = BR_RB;
        else if (idx == '1) state_n = BF_RA;
        else idx_n = idx + 1'b1;
      end
      BR_RB:  begin state_n = BR_CAP; op_a_n = r_data; end
      BR_CAP: begin state_n = BR_WA; w_data_n = r_data; op_b_n = op_a; end
      BR_WA:  begin state_n = BR_WB; w_data_n = op_b; end
      BR_WB: begin
        if (idx == '1) state_n = BF_RA;
        else begin
          state_n = BR_RA;
          idx_n   = idx + 1'b1;
        end
      end
      BF_RA:  state_n = BF_RB;
      BF_RB:  begin state_n = BF_CAP; op_a_n = r_data; end
      BF_CAP: begin state_n = BF_WA; w_data_n = {a_re, a_im}; op_b_n = {b_re, b_im}; end
      BF_WA:  begin state_n = BF_WB; w_data_n = op_b; end
      BF_WB: begin
        state_n = BF_RA;
        if (bfly == '1) begin
          bfly_n = '0;
          if (stg == SW'(LOG2N-1)) state_n = DONE;
          else stg_n = stg + 1'b1;
        end else begin
          bfly_n = bfly + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they change only on clock edges
  always_comb begin
    ready_n   = 1'b0;
    cs_n      = 1'b0;
    we_n      = 1'b0;
    addr_n    = addr;
    tw_addr_n = tw_addr;
    case (state_n)
      IDLE:  ready_n = 1'b1;
      BR_RA: begin cs_n = (idx_n < rev_n); addr_n = idx_n; end
      BR_RB: begin cs_n = 1'b1; addr_n = rev_n; end
      BR_WA: begin cs_n = 1'b1; we_n = 1'b1; addr_n = idx_n; end
      BR_WB: begin cs_n = 1'b1; we_n = 1'b1; addr_n = rev_n; end
      BF_RA: begin cs_n = 1'b1; addr_n = lo_n; tw_addr_n = k_n; end
      BF_RB: begin cs_n = 1'b1; addr_n = hi_n; end
      BF_WA: begin cs_n = 1'b1; we_n = 1'b1; addr_n = lo_n; end
      BF_WB: begin cs_n = 1'b1; we_n = 1'b1; addr_n = hi_n; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      stg     <= '0;
      bfly    <= '0;
      inv_q   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      ready   <= 1'b1;
      cs      <= 1'b0;
      we      <= 1'b0;
      addr    <= '0;
      w_data  <= '0;
      tw_addr <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      stg     <= stg_n;
      bfly    <= bfly_n;
      inv_q   <= inv_n;
      op_a    <= op_a_n;
      op_b    <= op_b_n;
      ready   <= ready_n;
      cs      <= cs_n;
      we      <= we_n;
      addr    <= addr_n;
      w_data  <= w_data_n;
      tw_addr <= tw_addr_n;
    end
  end
endmodule

// File: tb/tb_fft_r2_core.sv
// Directed bench for fft_r2_core at N=8: hand-computed spectra, latency, busy-start and reset cases,
// plus a word-by-word reference model for random data.
module tb_fft_r2_core;
  localparam int LOG2N = 3;
  localparam int DW    = 16;
  localparam int N     = 1 << LOG2N;

  logic clk = 1'b0;
  logic reset, start, inv, ready, cs, we, load;
  logic [LOG2N-1:0] addr;
  logic [LOG2N-2:0] tw_addr;
  logic [2*DW-1:0]  w_data, r_data, tw_data;

  logic [31:0] mem   [N];
  logic [31:0] stim  [N];
  logic [31:0] model [N];
  logic [31:0] hand  [N];
  logic [31:0] rom   [N/2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_r2_core #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .inv(inv), .ready(ready),
    .cs(cs), .we(we), .addr(addr), .w_data(w_data), .r_data(r_data),
    .tw_addr(tw_addr), .tw_data(tw_data)
  );

  // Memory with 1-cycle read latency and a registered twiddle ROM
  always @(posedge clk) begin
    if (load) for (int i = 0; i < N; i++) mem[i] <= stim[i];
    else if (cs && we) mem[addr] <= w_data;
    if (cs && !we) r_data <= mem[addr];
    tw_data <= rom[tw_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic int bitRev(input int v);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) if (v[b]) r |= 1 << (LOG2N-1-b);
    return r;
  endfunction

  function automatic longint wrap17(input longint v);
    logic signed [16:0] t;
    t = v[16:0];
    return longint'(t);
  endfunction

  function automatic logic [15:0] reduce(input longint v);
    longint t;
`ifdef FFT_STAGE_SCALE_EN
    t = wrap17(v) >>> 1;
`else
    t = v;
`endif
    return t[15:0];
  endfunction

  task automatic modelFft(input bit inv_sel);
    logic [31:0] tmp;
    longint ar, ai, br, bi, wr, wi, tr, ti;
    int a, b, k, r, half;
    for (int i = 0; i < N; i++) begin
      r = bitRev(i);
      if (i < r) begin tmp = model[i]; model[i] = model[r]; model[r] = tmp; end
    end
    for (int s = 0; s < LOG2N; s++) begin
      half = 1 << s;
      for (int g = 0; g < N; g += 2*half)
        for (int o = 0; o < half; o++) begin
          a = g + o; b = a + half; k = o * (N / (2*half));
          ar = longint'($signed(model[a][31:16])); ai = longint'($signed(model[a][15:0]));
          br = longint'($signed(model[b][31:16])); bi = longint'($signed(model[b][15:0]));
          wr = longint'($signed(rom[k][31:16]));   wi = longint'($signed(rom[k][15:0]));
          if (inv_sel) wi = -wi;
          tr = wrap17((br*wr - bi*wi) >>> 15);
          ti = wrap17((br*wi + bi*wr) >>> 15);
          model[a] = {reduce(ar+tr), reduce(ai+ti)};
          model[b] = {reduce(ar-tr), reduce(ai-ti)};
        end
    end
  endtask

  task automatic loadMem();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int i = 0; i < N; i++) model[i] = stim[i];
  endtask

  // Pulses start; optionally fires a second start with flipped inv while busy
  task automatic applyStimulus(input bit inv_sel, input bit poke_busy, output int cycles);
    @(negedge clk); start = 1'b1; inv = inv_sel;
    @(negedge clk); start = 1'b0; inv = 1'b0;
    checkOutput("ready_fall", {31'b0, ready}, 32'd0);
    cycles = 0;
    while (!ready && cycles < 2000) begin
      start = poke_busy && (cycles == 10);
      inv   = poke_busy && (cycles == 10) && !inv_sel;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0; inv = 1'b0;
    checkOutput("ready_rise", {31'b0, ready}, 32'd1);
  endtask

  task automatic compareMem(input string tag, input bit use_hand);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), mem[i], use_hand ? hand[i] : model[i]);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; inv = 1'b0; load = 1'b0;
    rom[0] = 32'h7FFF_0000; rom[1] = 32'h5A82_A57E;
    rom[2] = 32'h0000_8000; rom[3] = 32'hA57E_A57E;
    #12;
    checkOutput("rst_ready", {31'b0, ready}, 32'd1);
    checkOutput("rst_cs", {31'b0, cs}, 32'd0);
    checkOutput("rst_we", {31'b0, we}, 32'd0);
    checkOutput("rst_addr", {29'b0, addr}, 32'd0);
    checkOutput("rst_wdata", w_data, 32'd0);
    checkOutput("rst_twaddr", {30'b0, tw_addr}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Impulse at x[0]; a busy start with inv flipped must not disturb count or result
    for (int i = 0; i < N; i++) stim[i] = 32'h0;
    stim[0] = 32'h0100_0000;
    loadMem(); modelFft(1'b0);
    applyStimulus(1'b0, 1'b1, cyc);
    checkOutput("latency_imp", 32'(cyc), 32'd77);
    compareMem("imp_model", 1'b0);
`ifndef FFT_STAGE_SCALE_EN
    for (int i = 0; i < N; i++) hand[i] = 32'h0100_0000;
    compareMem("imp_hand", 1'b1);
`endif

    // Impulse at x[1], forward then inverse from the same input
    for (int i = 0; i < N; i++) stim[i] = 32'h0;
    stim[1] = 32'h0100_0000;
    loadMem(); modelFft(1'b0);
    applyStimulus(1'b0, 1'b0, cyc);
    checkOutput("latency_d1", 32'(cyc), 32'd77);
    compareMem("d1_fwd_model", 1'b0);
`ifndef FFT_STAGE_SCALE_EN
    hand = '{32'h00FF_0000, 32'h00B5_FF4A, 32'h0000_FF00, 32'hFF4A_FF4A,
             32'hFF01_0000, 32'hFF4B_00B6, 32'h0000_0100, 32'h00B6_00B6};
    compareMem("d1_fwd_hand", 1'b1);
`endif
    loadMem(); modelFft(1'b1);
    applyStimulus(1'b1, 1'b0, cyc);
    compareMem("d1_inv_model", 1'b0);
`ifndef FFT_STAGE_SCALE_EN
    hand = '{32'h00FF_0000, 32'h00B5_00B5, 32'h0000_0100, 32'hFF4A_00B5,
             32'hFF01_0000, 32'hFF4B_FF4B, 32'h0000_FF00, 32'h00B6_FF4B};
    compareMem("d1_inv_hand", 1'b1);
`endif

    // Small random data: forward then inverse on the result left in memory
    for (int i = 0; i < N; i++)
      stim[i] = {16'($urandom_range(0, 128)) - 16'd64, 16'($urandom_range(0, 128)) - 16'd64};
    loadMem(); modelFft(1'b0);
    applyStimulus(1'b0, 1'b0, cyc);
    compareMem("rnd_fwd", 1'b0);
    modelFft(1'b1);
    applyStimulus(1'b1, 1'b0, cyc);
    compareMem("rnd_inv", 1'b0);

    // Full-range random data exercises overflow handling
    for (int i = 0; i < N; i++) stim[i] = $urandom;
    loadMem(); modelFft(1'b0);
    applyStimulus(1'b0, 1'b0, cyc);
    compareMem("big_fwd", 1'b0);

    // Reset mid-butterfly (cycle 30 lands in BF_WB), then a full rerun
    loadMem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'b0, ready}, 32'd1);
    checkOutput("midrst_cs", {31'b0, cs}, 32'd0);
    checkOutput("midrst_we", {31'b0, we}, 32'd0);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < N; i++) stim[i] = 32'h0;
    stim[0] = 32'h0100_0000;
    loadMem(); modelFft(1'b0);
    applyStimulus(1'b0, 1'b0, cyc);
    checkOutput("latency_rerun", 32'(cyc), 32'd77);
    compareMem("rerun", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_r2_core.md
FFT_R2_CORE -- requirements
Module: fft_r2_core

Interface
REQ-001 Parameter: LOG2N, default 10, log2 of transform length N (3..12).
REQ-002 Parameter: DW, default 16, bits per real/imag component, two's complement, Q1.(DW-1).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse launching a transform; sampled only when ready=1.
REQ-006 inv  in  1  sampled with start; 1 selects inverse transform (conjugated twiddles).
REQ-007 ready  out  1  1 = idle/done, 0 = transform in progress.
REQ-008 cs, we  out  1 each  memory select and write enable.
REQ-009 addr  out  LOG2N  memory word address.
REQ-010 w_data  out  2*DW  write word {re, im}, re in upper half.
REQ-011 r_data  in  2*DW  read word, valid the cycle after a cs=1, we=0 request (1-cycle latency).
REQ-012 tw_addr  out  LOG2N-1  twiddle ROM address k, ROM holds W_N^k = exp(-j2*pi*k/N).
REQ-013 tw_data  in  2*DW  twiddle {cos, -sin} word, valid one cycle after tw_addr.

Function
REQ-014 Core performs an in-place radix-2 DIT FFT of N words held in external memory.
REQ-015 States: IDLE, BR_RA, BR_RB, BR_CAP, BR_WA, BR_WB, BF_RA, BF_RB, BF_CAP, BF_WA, BF_WB, DONE.
REQ-016 IDLE: ready=1, cs=0; start=1 -> BR phase with index i=0, ready=0 next cycle.
REQ-017 Bit-reverse phase: per i in 0..N-1, if i<rev(i) swap via BR_RA(read i), BR_RB(read rev(i), capture i), BR_CAP(capture rev(i)), BR_WA(write i), BR_WB(write rev(i)); else spend one cycle in BR_RA with cs=0.
REQ-018 Butterfly phase: stages s=0..LOG2N-1, N/2 butterflies each, order ascending group then ascending offset.
REQ-019 Butterfly pair a, b=a+2^s; twiddle k=offset*2^(LOG2N-1-s); tw_addr driven in BF_RA.
REQ-020 Butterfly sequence BF_RA(read a), BF_RB(read b, capture A), BF_CAP(capture B, W), BF_WA(write A'), BF_WB(write B'): 5 cycles.
REQ-021 T = B*W (W imag negated when inv=1); full 2*DW products summed, arithmetic shift right DW-1, truncate to DW+1 bits.
REQ-022 A' = A+T, B' = A-T computed at DW+1 bits, then reduced per REQ-031/REQ-032.
REQ-023 After last butterfly -> DONE (1 cycle, cs=0) -> IDLE with ready=1.
REQ-024 Latency start->ready rise = 1 + N + 4*S + 5*(N/2)*LOG2N cycles, S = number of swapped pairs.
REQ-025 start or inv changes while ready=0 are ignored.
REQ-026 cs=1 only in RA/RB/WA/WB states; we=1 only in WA/WB; w_data undefined-free (held) otherwise.

Reset
REQ-027 reset=1 forces IDLE immediately regardless of clk, including mid-transform.
REQ-028 Reset values: ready=1, cs=0, we=0, addr=0, w_data=0, tw_addr=0; all counters and captured operands 0.
REQ-029 Memory contents after mid-transform reset are not restored; next start runs a full transform.
REQ-030 No output glitches on reset release; first start accepted on first rising edge after release.

Configuration
REQ-031 Macro FFT_STAGE_SCALE_EN defined: A', B' arithmetic-shifted right 1 (truncate) per stage, total 1/N scaling, never overflows.
REQ-032 Macro FFT_STAGE_SCALE_EN undefined: A', B' truncated to low DW bits (wrap-around on overflow), no scaling.

Verification
REQ-033 LOG2N=10, DW=16, scale on: x[0]=0x4000_0000, others 0, start -> all 1024 outputs re=0x0010 +/-1, im=0 +/-1.
REQ-034 LOG2N=10, scale on: all x=0x0100_0000 -> X[0]=0x0100_0000 +/-1 LSB, X[1..1023] = 0 +/-1 LSB.
REQ-035 LOG2N=3: start pulse -> ready falls next cycle, rises exactly 77 cycles after start edge; second start while busy -> no effect on count.
REQ-036 Forward then inv=1 on same memory, scale off, input x[n] with |x|<=0x0040 -> output = N*x[n] +/-N LSB.
REQ-037 reset asserted at cycle 500 of a transform -> ready=1, cs=0 same cycle; new start -> correct REQ-033 result.
REQ-038 Bench memory model: 1-cycle read latency; cs=1, we=1 writes w_data at addr on rising edge; checker compares against C reference model per word.
